pe_ws_os: RTL and testbench
===========================

Name: pe_ws_os

Overview:
- Next-generation systolic PE for the tensor core array: int8 × int8 MAC with wide accumulation.
- Two dataflow modes, selected by pe_mode:
  - Weight-stationary (WS): index-matched weight capture with signal-eating, and double-buffered weights switched by a west-flowing pulse.
  - Output-stationary (OS): the PE holds its accumulator locally and drains finished results south through a small result FIFO.
- Adds optional saturation with a sticky overflow flag.
- One instance sits at each array node. North/south carry the weight/psum chain; west/east carry activations and control.

Parameters:
- ROW_ID, 0, static row index of this PE; matched against pe_index_in in WS mode.
- SYSTOLIC_ARRAY_WIDTH, 16, array dimension. IW = $clog2(SYSTOLIC_ARRAY_WIDTH).
- DATA_WIDTH_IN, 8, signed width of weight and activation.
- DATA_WIDTH_ACCUM, 32, signed width of psum and accumulator.
- SATURATE, 1, 1 = clamp additions to the signed ACCUM range; 0 = two's-complement wrap.
- DRAIN_DEPTH, 2, OS result FIFO entries (≥2).

Ports:
- clk in 1: clock, rising edge.
- rst_n in 1: asynchronous active-low reset.
- pe_enabled in 1: synchronous clear of all state and outputs when low.
- pe_mode in 1: 0 = WS, 1 = OS. Sampled into mode_q only while pe_enabled=0.
- pe_valid_in in 1: activation valid (west).
- pe_switch_in in 1: WS weight-bank switch (west).
- pe_last_in in 1: OS last element of a dot product (west).
- pe_input_in in DATA_WIDTH_IN: signed activation (west).
- pe_accept_w_in in 1: weight-stream valid (north).
- pe_weight_in in DATA_WIDTH_IN: signed weight (north).
- pe_index_in in IW: weight target row (north).
- pe_psum_in in DATA_WIDTH_ACCUM: upstream psum or drained result (north).
- pe_psum_valid_in in 1: pe_psum_in is valid (north).
- pe_input_out, pe_valid_out, pe_switch_out, pe_last_out out (DATA_WIDTH_IN, 1, 1, 1): east copies of the west inputs, 1-cycle delay.
- pe_weight_out, pe_index_out, pe_accept_w_out out (DATA_WIDTH_IN, IW, 1): south weight stream.
- pe_psum_out out DATA_WIDTH_ACCUM: south psum or result.
- pe_psum_valid_out out 1: pe_psum_out valid.
- pe_sat_flag out 1: sticky, set on any saturation event.
- pe_drain_ovf out 1: sticky, set when the result FIFO drops an entry.

Behaviour:

Reset and clear:
- rst_n=0 (async) clears every output, the weight banks, the accumulator, the FIFO, both sticky flags, and mode_q.
- pe_enabled=0 does the same synchronously, except that mode_q <= pe_mode.

Pass-through (both modes):
- All outputs are registered; east and weight pass-through latency is 1 cycle.
- pe_input/valid/switch/last_out copy their west inputs.
- pe_weight_out and pe_index_out always copy their north inputs.

Arithmetic:
- prod = pe_input_in × weight, signed, full 2·DATA_WIDTH_IN bits, sign-extended.
- sum = prod + addend.
- SATURATE=1: clamp sum to [-2^(ACCUM-1), 2^(ACCUM-1)-1] and set pe_sat_flag.
- SATURATE=0: wrap; pe_sat_flag never sets.

WS mode (mode_q=0):
- Psum: if pe_valid_in, psum_out <= sat(pe_input_in×active + pe_psum_in); else psum_out <= pe_psum_in.
- pe_psum_valid_out <= pe_valid_in | pe_psum_valid_in.
- Weight capture with signal-eating:
  - accept && index==ROW_ID: inactive <= pe_weight_in; accept_w_out <= 0.
  - accept && no match: accept_w_out <= 1.
  - otherwise: accept_w_out <= 0.
- Switch: pe_switch_in → active <= inactive (the old inactive).
- Switch and capture in the same cycle: active gets the old inactive; inactive gets the new weight.
- MAC in the switch cycle uses the old active.

OS mode (mode_q=1):
- pe_accept_w_out <= pe_accept_w_in; no eating, index ignored.
- MAC fires when pe_valid_in && pe_accept_w_in: acc <= sat(acc + pe_input_in×pe_weight_in).
- If pe_last_in is also high on a firing cycle: push sat(acc+prod) into the FIFO and set acc <= 0.
- pe_last_in without a firing cycle is ignored, apart from its east propagation.
- FIFO pushes per edge, in order:
  - own result first;
  - then pe_psum_in if pe_psum_valid_in.
- Pop: each edge, if the FIFO is non-empty, pop the head into pe_psum_out and set pe_psum_valid_out=1; otherwise pe_psum_valid_out=0 and pe_psum_out holds.
- Free-slot count is evaluated after the same-edge pop; there is no bypass.
- Own result reaches pe_psum_out 2 edges after its last-element edge, if the FIFO was empty.
- A push into a full FIFO is dropped and sets pe_drain_ovf. When only one slot is free, the own result is kept and the upstream entry is dropped.

Mode changes:
- pe_mode toggling while pe_enabled=1 has no effect.

Test Plan:
1. WS load/switch (ROW_ID=3):
   - Stream weights 5,7,-2 at index 1,3,5 with accept=1 → inactive=7; accept_w_out is 1,0,1 across the three cycles.
   - Switch, then input=4, psum_in=10 → psum_out=38 one cycle later.
2. WS same-cycle switch and capture: inactive=7, active=2; switch with a matching weight 9 while input=3, psum_in=0 → psum_out=6, then active=7, inactive=9.
3. OS dot product:
   - Inputs (2,3),(−4,5),(6,−1) with valid=accept=1, last on the third → pe_psum_out=−20, valid 2 cycles after the last edge.
   - acc=0 afterwards.
4. Saturation (SATURATE=1): WS psum_in=2^31−10, input=127, weight=127 → psum_out=2^31−1 and pe_sat_flag=1. The flag stays set until pe_enabled=0.
5. OS drain collision (DRAIN_DEPTH=2):
   - Own result and upstream valid in the same cycle → outputs appear on consecutive cycles, own first.
   - Force a third push while full → pe_drain_ovf=1 and the upstream value is lost.
6. Async reset mid-accumulation: rst_n=0 between edges → all outputs 0 immediately; after release, pe_mode=1 is ignored until pe_enabled pulses low.

Source files
------------

// File: rtl/pe_ws_os.sv
// Systolic int8 MAC processing element with weight-stationary and output-stationary
// dataflows, optional saturating accumulation and an OS result drain FIFO.
module pe_ws_os #(
  parameter int ROW_ID               = 0,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_IN        = 8,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int SATURATE             = 1,
  parameter int DRAIN_DEPTH          = 2,
  localparam int IW = $clog2(SYSTOLIC_ARRAY_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pe_enabled,
  input  logic                        pe_mode,
  input  logic                        pe_valid_in,
  input  logic                        pe_switch_in,
  input  logic                        pe_last_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_input_in,
  input  logic                        pe_accept_w_in,
  input  logic [DATA_WIDTH_IN-1:0]    pe_weight_in,
  input  logic [IW-1:0]               pe_index_in,
  input  logic [DATA_WIDTH_ACCUM-1:0] pe_psum_in,
  input  logic                        pe_psum_valid_in,
  output logic [DATA_WIDTH_IN-1:0]    pe_input_out,
  output logic                        pe_valid_out,
  output logic                        pe_switch_out,
  output logic                        pe_last_out,
  output logic [DATA_WIDTH_IN-1:0]    pe_weight_out,
  output logic [IW-1:0]               pe_index_out,
  output logic                        pe_accept_w_out,
  output logic [DATA_WIDTH_ACCUM-1:0] pe_psum_out,
  output logic                        pe_psum_valid_out,
  output logic                        pe_sat_flag,
  output logic                        pe_drain_ovf
);
  localparam int DW = DATA_WIDTH_IN;
  localparam int AW = DATA_WIDTH_ACCUM;
  localparam int PW = 2 * DW;
  localparam int CW = $clog2(DRAIN_DEPTH + 1);
  localparam logic [AW-1:0] SMAX    = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SMIN    = {1'b1, {(AW-1){1'b0}}};
  localparam logic [CW-1:0] DEPTH_C = CW'(DRAIN_DEPTH);
  localparam logic [IW-1:0] ROW_C   = IW'(ROW_ID);

  typedef struct packed {
    logic [DW-1:0]                  east_data;
    logic                           east_valid;
    logic                           east_switch;
    logic                           east_last;
    logic [DW-1:0]                  south_weight;
    logic [IW-1:0]                  south_index;
    logic                           south_accept;
    logic [AW-1:0]                  psum;
    logic                           psum_valid;
    logic                           sat;
    logic                           drain_ovf;
    logic [DW-1:0]                  w_active;
    logic [DW-1:0]                  w_inactive;
    logic [AW-1:0]                  acc;
    logic [DRAIN_DEPTH-1:0][AW-1:0] fifo;
    logic [CW-1:0]                  cnt;
  } st_t;

  st_t  st;
  logic mode_q;

  // Returns {saturated, result}; the flag is only raised when clamping is enabled.
  function automatic logic [AW:0] sat_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {a[AW-1], a} + {b[AW-1], b};
    if (SATURATE != 0 && s[AW] != s[AW-1]) return {1'b1, s[AW] ? SMIN : SMAX};
    return {1'b0, s[AW-1:0]};
  endfunction

  logic signed [PW-1:0] prod_ws, prod_os;
  logic [AW:0]          ws_res, os_res;
  logic                 fire, push_own, push_up, match;

  assign prod_ws  = $signed(pe_input_in) * $signed(st.w_active);
  assign prod_os  = $signed(pe_input_in) * $signed(pe_weight_in);
  assign ws_res   = sat_add({{(AW-PW){prod_ws[PW-1]}}, prod_ws}, pe_psum_in);
  assign os_res   = sat_add(st.acc, {{(AW-PW){prod_os[PW-1]}}, prod_os});
  assign fire     = pe_valid_in & pe_accept_w_in;
  assign push_own = mode_q & fire & pe_last_in;
  assign push_up  = mode_q & pe_psum_valid_in;
  assign match    = pe_accept_w_in && (pe_index_in == ROW_C);

  // Pop first, then own result, then upstream; free slots counted after the pop.
  logic [DRAIN_DEPTH-1:0][AW-1:0] fifo_n;
  logic [CW-1:0]                  cnt_n;
  logic                           drop;
  always_comb begin
    fifo_n = st.fifo;
    cnt_n  = st.cnt;
    drop   = 1'b0;
    if (st.cnt != '0) begin
      for (int i = 0; i < DRAIN_DEPTH - 1; i++) fifo_n[i] = st.fifo[i+1];
      cnt_n = st.cnt - 1'b1;
    end
    if (push_own) begin
      if (cnt_n == DEPTH_C) drop = 1'b1;
      else begin
        for (int i = 0; i < DRAIN_DEPTH; i++) if (cnt_n == CW'(i)) fifo_n[i] = os_res[AW-1:0];
        cnt_n = cnt_n + 1'b1;
      end
    end
    if (push_up) begin
      if (cnt_n == DEPTH_C) drop = 1'b1;
      else begin
        for (int i = 0; i < DRAIN_DEPTH; i++) if (cnt_n == CW'(i)) fifo_n[i] = pe_psum_in;
        cnt_n = cnt_n + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= '0;
      mode_q <= 1'b0;
    end else if (!pe_enabled) begin
      st     <= '0;
      mode_q <= pe_mode;
    end else begin
      st.east_data    <= pe_input_in;
      st.east_valid   <= pe_valid_in;
      st.east_switch  <= pe_switch_in;
      st.east_last    <= pe_last_in;
      st.south_weight <= pe_weight_in;
      st.south_index  <= pe_index_in;
      if (!mode_q) begin
        st.psum         <= pe_valid_in ? ws_res[AW-1:0] : pe_psum_in;
        st.psum_valid   <= pe_valid_in | pe_psum_valid_in;
        st.south_accept <= pe_accept_w_in && !match;
        if (pe_valid_in && ws_res[AW]) st.sat <= 1'b1;
        // Switch takes the pre-edge inactive bank even if a capture lands this cycle.
        if (pe_switch_in) st.w_active <= st.w_inactive;
        if (match) st.w_inactive <= pe_weight_in;
      end else begin
        st.south_accept <= pe_accept_w_in;
        if (fire) begin
          st.acc <= pe_last_in ? '0 : os_res[AW-1:0];
          if (os_res[AW]) st.sat <= 1'b1;
        end
        if (st.cnt != '0) begin
          st.psum       <= st.fifo[0];
          st.psum_valid <= 1'b1;
        end else begin
          st.psum_valid <= 1'b0;
        end
        st.fifo <= fifo_n;
        st.cnt  <= cnt_n;
        if (drop) st.drain_ovf <= 1'b1;
      end
    end
  end

  assign pe_input_out      = st.east_data;
  assign pe_valid_out      = st.east_valid;
  assign pe_switch_out     = st.east_switch;
  assign pe_last_out       = st.east_last;
  assign pe_weight_out     = st.south_weight;
  assign pe_index_out      = st.south_index;
  assign pe_accept_w_out   = st.south_accept;
  assign pe_psum_out       = st.psum;
  assign pe_psum_valid_out = st.psum_valid;
  assign pe_sat_flag       = st.sat;
  assign pe_drain_ovf      = st.drain_ovf;
endmodule

// File: tb/tb_pe_ws_os.sv
// Bench for pe_ws_os: directed table, OS/reset sequences and random traffic vs a queue model.
module tb_pe_ws_os;
  localparam int ROW = 3;
  localparam int DEPTH = 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic clk, rst_n, pe_enabled, pe_mode, pe_valid_in, pe_switch_in, pe_last_in;
  logic signed [7:0] pe_input_in, pe_weight_in, pe_input_out, pe_weight_out;
  logic pe_accept_w_in, pe_psum_valid_in;
  logic [3:0] pe_index_in, pe_index_out;
  logic signed [31:0] pe_psum_in, pe_psum_out;
  logic pe_valid_out, pe_switch_out, pe_last_out, pe_accept_w_out, pe_psum_valid_out;
  logic pe_sat_flag, pe_drain_ovf;

  pe_ws_os #(.ROW_ID(ROW), .SYSTOLIC_ARRAY_WIDTH(16), .DATA_WIDTH_IN(8), .DATA_WIDTH_ACCUM(32),
             .SATURATE(1), .DRAIN_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pe_enabled(pe_enabled), .pe_mode(pe_mode),
    .pe_valid_in(pe_valid_in), .pe_switch_in(pe_switch_in), .pe_last_in(pe_last_in),
    .pe_input_in(pe_input_in), .pe_accept_w_in(pe_accept_w_in), .pe_weight_in(pe_weight_in),
    .pe_index_in(pe_index_in), .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in),
    .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out), .pe_switch_out(pe_switch_out),
    .pe_last_out(pe_last_out), .pe_weight_out(pe_weight_out), .pe_index_out(pe_index_out),
    .pe_accept_w_out(pe_accept_w_out), .pe_psum_out(pe_psum_out),
    .pe_psum_valid_out(pe_psum_valid_out), .pe_sat_flag(pe_sat_flag), .pe_drain_ovf(pe_drain_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic en, mode, valid, sw, last, acc, pv;
    logic signed [7:0] inp, w;
    logic [3:0] idx;
    logic signed [31:0] psum;
  } in_t;

  typedef struct {
    in_t i;
    longint psum;
    bit pv, accw, sat;
  } rec_t;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_mode;
  longint m_act, m_inact, m_acc;
  longint q[$];
  longint e_psum, e_inp, e_w, e_idx;
  bit e_pv, e_accw, e_sat, e_ovf, e_valid, e_sw, e_last;

  task automatic check(input string nm, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic longint clampf(input longint s);
    if (s > MAXV) begin e_sat = 1; return MAXV; end
    if (s < MINV) begin e_sat = 1; return MINV; end
    return s;
  endfunction

  function automatic void qpush(input longint v);
    if (q.size() < DEPTH) q.push_back(v);
    else e_ovf = 1;
  endfunction

  function automatic void model_clear();
    e_psum = 0; e_inp = 0; e_w = 0; e_idx = 0;
    e_pv = 0; e_accw = 0; e_sat = 0; e_ovf = 0; e_valid = 0; e_sw = 0; e_last = 0;
    m_act = 0; m_inact = 0; m_acc = 0;
    q.delete();
  endfunction

  function automatic void model(input in_t x);
    longint nxt, s;
    if (!x.en) begin
      model_clear();
      m_mode = int'(x.mode);
      return;
    end
    e_inp = x.inp; e_valid = x.valid; e_sw = x.sw; e_last = x.last; e_w = x.w; e_idx = x.idx;
    if (m_mode == 0) begin
      e_psum = x.valid ? clampf(x.inp * m_act + x.psum) : longint'(x.psum);
      e_pv   = x.valid | x.pv;
      e_accw = x.acc && (x.idx != ROW);
      nxt = (x.acc && x.idx == ROW) ? longint'(x.w) : m_inact;
      if (x.sw) m_act = m_inact;
      m_inact = nxt;
    end else begin
      e_accw = x.acc;
      if (q.size() > 0) begin e_psum = q.pop_front(); e_pv = 1; end
      else e_pv = 0;
      if (x.valid && x.acc) begin
        s = clampf(m_acc + x.inp * x.w);
        if (x.last) begin qpush(s); m_acc = 0; end
        else m_acc = s;
      end
      if (x.pv) qpush(x.psum);
    end
  endfunction

  task automatic compare_all();
    check("psum_out", pe_psum_out, e_psum);
    check("psum_valid_out", pe_psum_valid_out, e_pv);
    check("accept_w_out", pe_accept_w_out, e_accw);
    check("input_out", pe_input_out, e_inp);
    check("valid_out", pe_valid_out, e_valid);
    check("switch_out", pe_switch_out, e_sw);
    check("last_out", pe_last_out, e_last);
    check("weight_out", pe_weight_out, e_w);
    check("index_out", pe_index_out, e_idx);
    check("sat_flag", pe_sat_flag, e_sat);
    check("drain_ovf", pe_drain_ovf, e_ovf);
  endtask

  task automatic apply(input in_t x);
    pe_enabled = x.en; pe_mode = x.mode; pe_valid_in = x.valid; pe_switch_in = x.sw;
    pe_last_in = x.last; pe_accept_w_in = x.acc; pe_input_in = x.inp; pe_weight_in = x.w;
    pe_index_in = x.idx; pe_psum_in = x.psum; pe_psum_valid_in = x.pv;
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic cycle(input in_t x);
    apply(x);
    @(posedge clk);
    #1;
    model(x);
    compare_all();
    @(negedge clk);
  endtask

  function automatic in_t ws(bit v, bit s, bit a, int w, int idx, int inp, longint ps, bit pv);
    in_t x;
    x.en = 1; x.mode = 1'($urandom); x.last = 1'($urandom);
    x.valid = v; x.sw = s; x.acc = a; x.w = 8'(w); x.idx = 4'(idx);
    x.inp = 8'(inp); x.psum = 32'(ps); x.pv = pv;
    return x;
  endfunction

  function automatic in_t os(bit v, bit a, bit l, int inp, int w, longint ps, bit pv);
    in_t x;
    x.en = 1; x.mode = 1'($urandom); x.sw = 1'($urandom); x.idx = 4'($urandom);
    x.valid = v; x.acc = a; x.last = l; x.inp = 8'(inp); x.w = 8'(w);
    x.psum = 32'(ps); x.pv = pv;
    return x;
  endfunction

  function automatic in_t off(bit mode);
    in_t x;
    x = ws(1'($urandom), 1'($urandom), 1'($urandom), int'($urandom), int'($urandom),
           int'($urandom), longint'($urandom), 1'($urandom));
    x.en = 0; x.mode = mode;
    return x;
  endfunction

  function automatic in_t rnd(bit osm);
    in_t x;
    longint ps;
    ps = ($urandom % 8 == 0) ? MAXV - longint'($urandom_range(0, 20000)) : longint'(int'($urandom));
    if (osm)
      x = os($urandom % 4 != 0, $urandom % 4 != 0, $urandom % 4 == 0, int'($urandom),
             int'($urandom), ps, $urandom % 3 == 0);
    else
      x = ws(1'($urandom), $urandom % 5 == 0, 1'($urandom), int'($urandom),
             ($urandom % 3 == 0) ? ROW : int'($urandom % 16), int'($urandom), ps, 1'($urandom));
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rec_t tbl[17];
    in_t z;
    tbl[0]  = '{ws(0,0,1,5,1,0,0,0),          0,    0, 1, 0};
    tbl[1]  = '{ws(0,0,1,7,3,0,0,0),          0,    0, 0, 0};
    tbl[2]  = '{ws(0,0,1,-2,5,0,0,0),         0,    0, 1, 0};
    tbl[3]  = '{ws(0,1,0,0,0,0,0,0),          0,    0, 0, 0};
    tbl[4]  = '{ws(1,0,0,0,0,4,10,1),         38,   1, 0, 0};
    tbl[5]  = '{ws(0,0,1,2,3,0,0,0),          0,    0, 0, 0};
    tbl[6]  = '{ws(0,1,0,0,0,0,0,0),          0,    0, 0, 0};
    tbl[7]  = '{ws(0,0,1,7,3,0,0,0),          0,    0, 0, 0};
    tbl[8]  = '{ws(1,1,1,9,3,3,0,0),          6,    1, 0, 0};
    tbl[9]  = '{ws(1,0,0,0,0,1,0,0),          7,    1, 0, 0};
    tbl[10] = '{ws(0,1,0,0,0,0,0,0),          0,    0, 0, 0};
    tbl[11] = '{ws(1,0,0,0,0,1,0,0),          9,    1, 0, 0};
    tbl[12] = '{ws(0,0,1,127,3,0,0,0),        0,    0, 0, 0};
    tbl[13] = '{ws(0,1,0,0,0,0,0,0),          0,    0, 0, 0};
    tbl[14] = '{ws(1,0,0,0,0,127,MAXV-9,1),   MAXV, 1, 0, 1};
    tbl[15] = '{ws(0,0,0,0,0,0,5,1),          5,    1, 0, 1};
    tbl[16] = '{ws(1,0,0,0,0,-128,MINV,0),    MINV, 1, 0, 1};

    z = off(0);
    apply(z);
    rst_n = 0;
    model_clear();
    m_mode = 0;
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1;
    cycle(off(0));

    // WS load, switch, same-cycle switch+capture and saturation
    for (int k = 0; k < 17; k++) begin
      cycle(tbl[k].i);
      check($sformatf("tbl%0d_psum", k), pe_psum_out, tbl[k].psum);
      check($sformatf("tbl%0d_pvalid", k), pe_psum_valid_out, tbl[k].pv);
      check($sformatf("tbl%0d_accept_w", k), pe_accept_w_out, tbl[k].accw);
      check($sformatf("tbl%0d_sat", k), pe_sat_flag, tbl[k].sat);
    end

    // OS dot product and drain
    cycle(off(1));
    check("sat_cleared", pe_sat_flag, 0);
    cycle(os(1,1,0,2,3,0,0));
    cycle(os(1,1,0,-4,5,0,0));
    cycle(os(1,1,1,6,-1,0,0));
    check("os_no_bypass", pe_psum_valid_out, 0);
    cycle(os(0,0,1,0,0,0,0));
    check("os_dot_valid", pe_psum_valid_out, 1);
    check("os_dot_value", pe_psum_out, -20);
    cycle(os(1,1,1,1,1,0,0));
    cycle(os(0,0,0,0,0,0,0));
    check("os_acc_cleared", pe_psum_out, 1);
    cycle(os(1,1,1,2,2,100,1));
    cycle(os(1,1,1,3,3,200,1));
    check("coll_own_first", pe_psum_out, 4);
    check("coll_ovf", pe_drain_ovf, 1);
    cycle(os(0,0,0,0,0,0,0));
    check("coll_upstream", pe_psum_out, 100);
    cycle(os(0,0,0,0,0,0,0));
    check("coll_up_dropped", pe_psum_out, 9);
    cycle(os(0,0,0,0,0,0,0));
    check("fifo_empty_valid", pe_psum_valid_out, 0);
    check("fifo_empty_hold", pe_psum_out, 9);

    // async reset between edges, mid-accumulation
    cycle(os(1,1,0,5,5,0,0));
    #2 rst_n = 0;
    #1;
    model_clear();
    m_mode = 0;
    compare_all();
    @(negedge clk);
    rst_n = 1;
    z = os(1,1,0,3,4,10,1);
    z.mode = 1; z.idx = 0;
    cycle(z);
    check("mode_ignored_valid", pe_psum_valid_out, 1);
    check("mode_ignored_psum", pe_psum_out, 10);
    cycle(off(1));
    cycle(z);
    check("mode_taken_valid", pe_psum_valid_out, 0);
    cycle(os(0,0,0,0,0,0,0));
    check("mode_taken_drain", pe_psum_out, 10);

    // random traffic against the model
    cycle(off(0));
    for (int n = 0; n < 300; n++) cycle(rnd(0));
    cycle(off(1));
    for (int n = 0; n < 300; n++) cycle(rnd(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
